// File: rtl/pattern_pkg.sv
// Shared types and constants for the pattern sequencer: mode encodings, frame geometry
// and the layout of one configuration-table entry.
package pattern_pkg;

  typedef enum logic [2:0] {
    MODE_OFF = 3'd0,
    REGULAR  = 3'd1,
    CONST    = 3'd2,
    WHITE1X1 = 3'd3,
    BLACK1X1 = 3'd4,
    WHITE2X2 = 3'd5,
    BLACK2X2 = 3'd6,
    RAMP     = 3'd7
  } mode_e;

  localparam int LINES       = 24;
  localparam int ACT_REGULAR = 4096;
  localparam int ACT_OTHER   = 1290;
  localparam int ENTRIES     = 8;
  localparam int ENTRY_W     = 23;

  // Bit layout matches cfg_wdata: [22:20] mode, [19:18] X, [17:16] Y, [15:4] constVal, [3:0] frames-1.
  typedef struct packed {
    mode_e       mode;
    logic [1:0]  x;
    logic [1:0]  y;
    logic [11:0] const_val;
    logic [3:0]  frames_m1;
  } entry_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_LINE,
    ST_VGAP
  } state_e;

  // Last pixel-counter value of a line: P - 1 = ACT + H_BLANK.
  function automatic logic [12:0] line_last(logic [2:0] mode, int h_blank);
    return 13'(((mode == REGULAR) ? ACT_REGULAR : ACT_OTHER) + h_blank);
  endfunction

endpackage

// File: rtl/pattern_table.sv
// 8-entry configuration store for the sequencer: synchronous write, combinational read,
// cleared by reset so a restart after reset always sees an all-zero table.
module pattern_table
  import pattern_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_en,
  input  logic [2:0]         wr_addr,
  input  logic [ENTRY_W-1:0] wr_data,
  input  logic [2:0]         rd_addr,
  output logic [ENTRY_W-1:0] rd_data
);

  logic [ENTRY_W-1:0] mem_q [ENTRIES];
  logic [ENTRY_W-1:0] mem_d [ENTRIES];

  always_comb begin
    mem_d = mem_q;
    if (wr_en) mem_d[wr_addr] = wr_data;
  end

  // NOTE: this storage is reset on purpose -- a restart after reset must replay an all-zero
  // table -- so it lands in flops rather than a RAM macro, which could not be cleared this way.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/pattern_sequencer.sv
// Table-driven frame sequencer: walks the configured entries, times lines and vertical
// blanking, and drives sync plus held pattern settings to the pattern generator.
module pattern_sequencer
  import pattern_pkg::*;
#(
  parameter int H_BLANK = 16,
  parameter int V_BLANK = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cfg_we,
  input  logic [2:0]  cfg_addr,
  input  logic [22:0] cfg_wdata,
  input  logic [2:0]  last_idx,
  input  logic        loop_en,
  input  logic        start,
  input  logic        stop,
  output logic        f_sync,
  output logic        sync,
  output logic [2:0]  Mode,
  output logic [1:0]  X,
  output logic [1:0]  Y,
  output logic [11:0] constVal,
  output logic        busy,
  output logic [2:0]  entry_idx,
  output logic        frame_done,
  output logic        seq_done
);

  localparam logic [9:0] VC_LAST   = 10'(V_BLANK - 1);
  localparam logic [4:0] LINE_LAST = 5'(LINES - 1);

  state_e      state_q, state_d;
  logic [2:0]  entry_idx_q, entry_idx_d;
  logic [12:0] pc_q, pc_d;
  logic [4:0]  line_q, line_d;
  logic [9:0]  vc_q, vc_d;
  logic [4:0]  frames_left_q, frames_left_d;
  logic        stop_pending_q, stop_pending_d;
  logic [2:0]  mode_q, mode_d;
  logic [1:0]  x_q, x_d;
  logic [1:0]  y_q, y_d;
  logic [11:0] const_val_q, const_val_d;
  logic        sync_q, sync_d;
  logic        f_sync_q, f_sync_d;
  logic        frame_done_q, frame_done_d;
  logic        seq_done_q, seq_done_d;

  logic [ENTRY_W-1:0] rd_data;
  entry_t             rd_entry;
  logic [12:0]        pc_last;

  assign busy     = (state_q != ST_IDLE);
  assign rd_entry = entry_t'(rd_data);
  assign pc_last  = line_last(mode_q, H_BLANK);

  pattern_table u_table (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (cfg_we && !busy),
    .wr_addr (cfg_addr),
    .wr_data (cfg_wdata),
    .rd_addr (entry_idx_q),
    .rd_data (rd_data)
  );

  // NOTE: every variable gets its hold value before the case statement, so no path through
  // this block leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d        = state_q;
    entry_idx_d    = entry_idx_q;
    pc_d           = pc_q;
    line_d         = line_q;
    vc_d           = vc_q;
    frames_left_d  = frames_left_q;
    stop_pending_d = stop_pending_q;
    mode_d         = mode_q;
    x_d            = x_q;
    y_d            = y_q;
    const_val_d    = const_val_q;
    seq_done_d     = 1'b0;

    if (state_q != ST_IDLE && stop) stop_pending_d = 1'b1;

    unique case (state_q)
      ST_IDLE: begin
        // Clearing here also discards a stop that arrives together with start.
        stop_pending_d = 1'b0;
        if (start) begin
          state_d     = ST_LOAD;
          entry_idx_d = 3'd0;
        end
      end
      ST_LOAD: begin
        mode_d        = rd_entry.mode;
        x_d           = rd_entry.x;
        y_d           = rd_entry.y;
        const_val_d   = rd_entry.const_val;
        frames_left_d = {1'b0, rd_entry.frames_m1} + 5'd1;
        pc_d          = '0;
        line_d        = '0;
        state_d       = ST_LINE;
      end
      ST_LINE: begin
        if (pc_q == pc_last) begin
          pc_d = '0;
          if (line_q != LINE_LAST) begin
            line_d = line_q + 5'd1;
          end else begin
            vc_d    = '0;
            state_d = ST_VGAP;
          end
        end else begin
          pc_d = pc_q + 13'd1;
        end
      end
      ST_VGAP: begin
        if (vc_q == VC_LAST) begin
          frames_left_d = frames_left_q - 5'd1;
          pc_d          = '0;
          line_d        = '0;
          if (stop_pending_q) begin
            state_d = ST_IDLE;
          end else if (frames_left_d != 5'd0) begin
            state_d = ST_LINE;
          end else if (entry_idx_q < last_idx) begin
            entry_idx_d = entry_idx_q + 3'd1;
            state_d     = ST_LOAD;
          end else if (loop_en) begin
            entry_idx_d = 3'd0;
            state_d     = ST_LOAD;
          end else begin
            seq_done_d = 1'b1;
            state_d    = ST_IDLE;
          end
        end else begin
          vc_d = vc_q + 10'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Strobes are derived from next-state values so the registered copies line up with the
    // counters they describe.
    sync_d       = (state_d == ST_LINE) && (pc_d == '0);
    f_sync_d     = sync_d && (line_d == '0);
    frame_done_d = (state_d == ST_VGAP) && (vc_d == VC_LAST);
  end

  // NOTE: non-blocking assignments keep every flop sampling pre-edge values, so the order
  // of the statements below has no effect on behaviour.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      entry_idx_q    <= '0;
      pc_q           <= '0;
      line_q         <= '0;
      vc_q           <= '0;
      frames_left_q  <= '0;
      stop_pending_q <= 1'b0;
      mode_q         <= '0;
      x_q            <= '0;
      y_q            <= '0;
      const_val_q    <= '0;
      sync_q         <= 1'b0;
      f_sync_q       <= 1'b0;
      frame_done_q   <= 1'b0;
      seq_done_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      entry_idx_q    <= entry_idx_d;
      pc_q           <= pc_d;
      line_q         <= line_d;
      vc_q           <= vc_d;
      frames_left_q  <= frames_left_d;
      stop_pending_q <= stop_pending_d;
      mode_q         <= mode_d;
      x_q            <= x_d;
      y_q            <= y_d;
      const_val_q    <= const_val_d;
      sync_q         <= sync_d;
      f_sync_q       <= f_sync_d;
      frame_done_q   <= frame_done_d;
      seq_done_q     <= seq_done_d;
    end
  end

  assign f_sync     = f_sync_q;
  assign sync       = sync_q;
  assign Mode       = mode_q;
  assign X          = x_q;
  assign Y          = y_q;
  assign constVal   = const_val_q;
  assign entry_idx  = entry_idx_q;
  assign frame_done = frame_done_q;
  assign seq_done   = seq_done_q;

endmodule
